// File: rtl/note_tracker_pkg.sv
// Shared types and helpers for the note tracker: note record, FSM states,
// fixed-point octave size and the saturating IIR step.
package note_tracker_pkg;

    localparam int N = 16;

    typedef struct packed {
        logic [N-1:0] position;
        logic [N-1:0] amplitude;
        logic         valid;
    } note_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MATCH  = 3'd1,
        ST_PLACE  = 3'd2,
        ST_DECAY  = 3'd3,
        ST_OUTPUT = 3'd4
    } tracker_state_t;

    function automatic int unsigned bpo_fixed(input int unsigned bpo, input int unsigned fpf);
        return bpo << fpf;
    endfunction

    // amp + (new - amp) >>> k with the N+1-bit signed difference, clamped to [0, 2^N-1]
    function automatic logic [N-1:0] iir_update(input logic [N-1:0] cur,
                                                input logic [N-1:0] tgt,
                                                input logic [4:0]   k);
        logic [N:0]   diff;
        logic [N:0]   sh;
        logic [N+1:0] sum;
        diff = {1'b0, tgt} - {1'b0, cur};
        sh   = $unsigned($signed(diff) >>> k);
        sum  = {2'b00, cur} + {sh[N], sh};
        if (sum[N+1]) begin
            return '0;
        end else if (sum[N]) begin
            return '1;
        end else begin
            return sum[N-1:0];
        end
    endfunction

endpackage

// File: rtl/note_tracker_if.sv
// Frame-level bus between the peak stage and the note tracker.
interface note_tracker_if import note_tracker_pkg::*; #(
    parameter int NOTES = 12
);
    logic              start;
    note_t [NOTES-1:0] newPeaks;
    logic [4:0]        iirConst;
    logic [N-1:0]      minAmplitude;
    note_t [NOTES-1:0] outNotes;
    logic              finished;

    modport master (
        output start, newPeaks, iirConst, minAmplitude,
        input  outNotes, finished
    );

    modport slave (
        input  start, newPeaks, iirConst, minAmplitude,
        output outNotes, finished
    );
endinterface

// File: rtl/note_tracker_circ_distance.sv
// Wrap-around distance between two fixed-point positions on a circle of
// BPO bins; evaluated one bit wider than the positions so nothing overflows.
module note_tracker_circ_distance import note_tracker_pkg::*; #(
    parameter int NW  = 16,
    parameter int FPF = 10,
    parameter int BPO = 24
) (
    input  logic [NW-1:0] a,
    input  logic [NW-1:0] b,
    output logic [NW:0]   d
);
    localparam logic [NW:0] FULL = (NW+1)'(bpo_fixed(BPO, FPF));
    localparam logic [NW:0] HALF = FULL >> 1;

    logic [NW:0] raw_s;

    // absolute difference, folded onto the short way round
    always_comb begin
        if (a >= b) begin
            raw_s = {1'b0, a} - {1'b0, b};
        end else begin
            raw_s = {1'b0, b} - {1'b0, a};
        end
        if (raw_s > HALF) begin
            d = FULL - raw_s;
        end else begin
            d = raw_s;
        end
    end
endmodule

// File: rtl/note_tracker.sv
// Persistent note slot tracker: matches each frame's peaks to slots, filters,
// decays and allocates, then publishes the slot table with a finished pulse.
module note_tracker import note_tracker_pkg::*; #(
    parameter int FPF     = 10,
    parameter int BPO     = 24,
    parameter int NOTES   = 12,
    parameter int ASSDIST = 1 << FPF,
    parameter int MAXAGE  = 7
) (
    input logic          clk,
    input logic          rst,
    note_tracker_if.slave bus
);
    localparam int IW = (NOTES > 1) ? $clog2(NOTES) : 1;
    localparam int AW = $clog2(MAXAGE + 1);
    localparam logic [N-1:0]  FULL_N    = N'(bpo_fixed(BPO, FPF));
    localparam logic [N:0]    ASSDIST_W = (N+1)'(ASSDIST);
    localparam logic [IW-1:0] LAST      = IW'(NOTES - 1);
    localparam logic [AW-1:0] AGE_LIMIT = AW'(MAXAGE);

    tracker_state_t    state_q, state_d;
    logic [IW-1:0]     p_q, p_d, s_q, s_d;
    logic              best_valid_q, best_valid_d;
    logic [IW-1:0]     best_idx_q, best_idx_d;
    logic [N:0]        best_dist_q, best_dist_d;
    note_t [NOTES-1:0] pk_q, pk_d;
    logic [NOTES-1:0]  matched_q, matched_d;
    logic [NOTES-1:0]  claimed_q, claimed_d;
    note_t [NOTES-1:0] slots_q, slots_d;
    logic [AW-1:0]     age_q [NOTES];
    logic [AW-1:0]     age_d [NOTES];
    logic [4:0]        k_q, k_d;
    logic [N-1:0]      min_amp_q, min_amp_d;
    note_t [NOTES-1:0] out_q, out_d;
    logic              finished_q, finished_d;

    logic [N:0]        dist_s;
    logic              cand_s;
    logic              sel_valid_s;
    logic [IW-1:0]     sel_idx_s;
    logic              free_valid_s;
    logic [IW-1:0]     free_idx_s;

    function automatic logic [N-1:0] wrap_pos(input logic [N-1:0] pos);
        return pos % FULL_N;
    endfunction

    note_tracker_circ_distance #(.NW(N), .FPF(FPF), .BPO(BPO)) u_dist (
        .a (pk_q[p_q].position),
        .b (slots_q[s_q].position),
        .d (dist_s)
    );

    // lowest-index empty slot
    always_comb begin
        free_valid_s = 1'b0;
        free_idx_s   = '0;
        for (int i = NOTES - 1; i >= 0; i--) begin
            if (!slots_q[i].valid) begin
                free_valid_s = 1'b1;
                free_idx_s   = IW'(i);
            end else begin
                free_valid_s = free_valid_s;
            end
        end
    end

    // frame sequencing and slot table next-state
    always_comb begin
        logic [N-1:0]  dec_amp;
        logic [AW-1:0] dec_age;
        state_d      = state_q;
        p_d          = p_q;
        s_d          = s_q;
        best_valid_d = best_valid_q;
        best_idx_d   = best_idx_q;
        best_dist_d  = best_dist_q;
        pk_d         = pk_q;
        matched_d    = matched_q;
        claimed_d    = claimed_q;
        slots_d      = slots_q;
        age_d        = age_q;
        k_d          = k_q;
        min_amp_d    = min_amp_q;
        out_d        = out_q;
        finished_d   = 1'b0;
        cand_s       = 1'b0;
        sel_valid_s  = best_valid_q;
        sel_idx_s    = best_idx_q;
        dec_amp      = '0;
        dec_age      = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    for (int i = 0; i < NOTES; i++) begin
                        pk_d[i]          = bus.newPeaks[i];
                        pk_d[i].position = wrap_pos(bus.newPeaks[i].position);
                    end
                    matched_d    = '0;
                    claimed_d    = '0;
                    k_d          = bus.iirConst;
                    min_amp_d    = bus.minAmplitude;
                    p_d          = '0;
                    s_d          = '0;
                    best_valid_d = 1'b0;
                    state_d      = ST_MATCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MATCH: begin
                cand_s = pk_q[p_q].valid && slots_q[s_q].valid && !claimed_q[s_q] &&
                         (dist_s <= ASSDIST_W) && (!best_valid_q || (dist_s < best_dist_q));
                if (cand_s) begin
                    sel_valid_s = 1'b1;
                    sel_idx_s   = s_q;
                    best_dist_d = dist_s;
                end else begin
                    best_dist_d = best_dist_q;
                end
                best_valid_d = sel_valid_s;
                best_idx_d   = sel_idx_s;
                if (s_q == LAST) begin
                    if (sel_valid_s) begin
                        slots_d[sel_idx_s].position  = pk_q[p_q].position;
                        slots_d[sel_idx_s].amplitude = iir_update(slots_q[sel_idx_s].amplitude,
                                                                  pk_q[p_q].amplitude, k_q);
                        age_d[sel_idx_s]     = '0;
                        claimed_d[sel_idx_s] = 1'b1;
                        matched_d[p_q]       = 1'b1;
                    end else begin
                        matched_d = matched_q;
                    end
                    best_valid_d = 1'b0;
                    s_d          = '0;
                    if (p_q == LAST) begin
                        p_d     = '0;
                        state_d = ST_PLACE;
                    end else begin
                        p_d = p_q + 1'b1;
                    end
                end else begin
                    s_d = s_q + 1'b1;
                end
            end
            ST_PLACE: begin
                if (pk_q[p_q].valid && !matched_q[p_q] && free_valid_s) begin
                    slots_d[free_idx_s]   = pk_q[p_q];
                    age_d[free_idx_s]     = '0;
                    claimed_d[free_idx_s] = 1'b1;
                end else begin
                    slots_d = slots_q;
                end
                if (p_q == LAST) begin
                    p_d     = '0;
                    state_d = ST_DECAY;
                end else begin
                    p_d = p_q + 1'b1;
                end
            end
            ST_DECAY: begin
                for (int i = 0; i < NOTES; i++) begin
                    dec_amp = slots_q[i].amplitude - (slots_q[i].amplitude >> k_q);
                    dec_age = age_q[i] + 1'b1;
                    if (slots_q[i].valid && !claimed_q[i]) begin
                        // k=0 wipes the amplitude, so the slot is gone regardless of threshold
                        if ((k_q == 5'd0) || (dec_amp < min_amp_q) || (dec_age >= AGE_LIMIT)) begin
                            slots_d[i] = '0;
                            age_d[i]   = '0;
                        end else begin
                            slots_d[i].amplitude = dec_amp;
                            age_d[i]             = dec_age;
                        end
                    end else begin
                        age_d[i] = age_q[i];
                    end
                end
                state_d = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                out_d      = slots_q;
                finished_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state registers, synchronous reset clears the whole table
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            p_q          <= '0;
            s_q          <= '0;
            best_valid_q <= 1'b0;
            best_idx_q   <= '0;
            best_dist_q  <= '0;
            pk_q         <= '0;
            matched_q    <= '0;
            claimed_q    <= '0;
            slots_q      <= '0;
            age_q        <= '{default: '0};
            k_q          <= '0;
            min_amp_q    <= '0;
            out_q        <= '0;
            finished_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            s_q          <= s_d;
            best_valid_q <= best_valid_d;
            best_idx_q   <= best_idx_d;
            best_dist_q  <= best_dist_d;
            pk_q         <= pk_d;
            matched_q    <= matched_d;
            claimed_q    <= claimed_d;
            slots_q      <= slots_d;
            age_q        <= age_d;
            k_q          <= k_d;
            min_amp_q    <= min_amp_d;
            out_q        <= out_d;
            finished_q   <= finished_d;
        end
    end

    assign bus.outNotes = out_q;
    assign bus.finished = finished_q;

endmodule

// File: tb/tb_note_tracker.sv
// Scoreboard bench for note_tracker: frames push expected tables, a monitor
// compares them whenever finished pulses.
module tb_note_tracker;
    import note_tracker_pkg::*;

    localparam int NOTES   = 12;
    localparam int LATENCY = NOTES * NOTES + NOTES + 2;

    typedef note_t [NOTES-1:0] table_t;

    logic   clk = 1'b0;
    logic   rst;
    int     checks = 0;
    int     errors = 0;
    table_t exp_q[$];
    table_t mon_e;

    always #5 clk = ~clk;

    note_tracker_if #(.NOTES(NOTES)) bus ();

    note_tracker #(.NOTES(NOTES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic note_t mk(input int pos, input int amp);
        note_t n;
        n.position  = 16'(pos);
        n.amplitude = 16'(amp);
        n.valid     = 1'b1;
        return n;
    endfunction

    // monitor: every finished pulse consumes one expected table
    always @(negedge clk) begin
        if (!rst && bus.finished) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL finished_unexpected got 1 want 0 at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                for (int i = 0; i < NOTES; i++) begin
                    checks++;
                    if (bus.outNotes[i] !== mon_e[i]) begin
                        errors++;
                        $display("FAIL slot%0d got pos=%0d amp=%0d v=%0b want pos=%0d amp=%0d v=%0b",
                                 i, bus.outNotes[i].position, bus.outNotes[i].amplitude,
                                 bus.outNotes[i].valid, mon_e[i].position,
                                 mon_e[i].amplitude, mon_e[i].valid);
                    end
                end
            end
        end
    end

    task automatic check_cleared(input string name);
        for (int i = 0; i < NOTES; i++) begin
            checks++;
            if (bus.outNotes[i] !== note_t'(0)) begin
                errors++;
                $display("FAIL %s_slot%0d got %h want 0", name, i, bus.outNotes[i]);
            end
        end
        checks++;
        if (bus.finished !== 1'b0) begin
            errors++;
            $display("FAIL %s_finished got %b want 0", name, bus.finished);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // one frame from IDLE: checks latency and single-cycle finished pulse
    task automatic run_frame(input table_t pk, input logic [4:0] k,
                             input logic [15:0] mina, input table_t ex);
        int n = 0;
        bus.newPeaks     = pk;
        bus.iirConst     = k;
        bus.minAmplitude = mina;
        exp_q.push_back(ex);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (bus.finished !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != LATENCY) begin
            errors++;
            $display("FAIL latency got %0d want %0d", n, LATENCY);
        end
        @(negedge clk);
        checks++;
        if (bus.finished !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width got %b want 0", bus.finished);
        end
        wait_drain(10);
    endtask

    initial begin
        table_t pk;
        table_t ex;

        // reset with start asserted: no frame may follow
        rst              = 1'b1;
        bus.start        = 1'b1;
        bus.newPeaks     = '0;
        bus.newPeaks[0]  = mk(100, 100);
        bus.iirConst     = 5'd0;
        bus.minAmplitude = 16'd0;
        repeat (5) @(negedge clk);
        bus.start = 1'b0;
        rst       = 1'b0;
        check_cleared("reset");
        repeat (170) @(negedge clk);
        check_cleared("reset_idle");

        // empty table, three peaks placed in ascending slots
        pk = '0; pk[0] = mk(555, 10000); pk[3] = mk(7282, 10000); pk[11] = mk(24545, 15775);
        ex = '0; ex[0] = mk(555, 10000); ex[1] = mk(7282, 10000); ex[2] = mk(24545, 15775);
        run_frame(pk, 5'd0, 16'd0, ex);

        // wrap-around match beats a farther slot; the other slot decays by half
        do_reset();
        pk = '0; pk[0] = mk(24545, 15775); pk[1] = mk(1000, 500);
        ex = pk;
        run_frame(pk, 5'd1, 16'd0, ex);
        pk = '0; pk[5] = mk(205, 7777);
        ex = '0; ex[0] = mk(205, 11776); ex[1] = mk(1000, 250);
        run_frame(pk, 5'd1, 16'd0, ex);

        // too far: new slot at lowest free index, old slot dropped by k=0
        do_reset();
        pk = '0; pk[0] = mk(8212, 20000);
        ex = pk;
        run_frame(pk, 5'd0, 16'd1, ex);
        pk = '0; pk[0] = mk(9427, 5000);
        ex = '0; ex[1] = mk(9427, 5000);
        run_frame(pk, 5'd0, 16'd1, ex);
        // distance exactly one bin still associates
        pk = '0; pk[2] = mk(10451, 6000);
        ex = '0; ex[1] = mk(10451, 6000);
        run_frame(pk, 5'd0, 16'd1, ex);

        // full table: unmatched peaks dropped, every slot decays by 1/8
        do_reset();
        for (int i = 0; i < NOTES; i++) pk[i] = mk(1024 * i + 512, 8000);
        ex = pk;
        run_frame(pk, 5'd3, 16'd100, ex);
        for (int j = 0; j < NOTES; j++) pk[j] = mk(13056 + 896 * j, 3000);
        for (int i = 0; i < NOTES; i++) ex[i] = mk(1024 * i + 512, 7000);
        run_frame(pk, 5'd3, 16'd100, ex);
        // no-decay frames age the slots until they hit the age limit
        pk = '0;
        for (int f = 0; f < 5; f++) run_frame(pk, 5'd31, 16'd0, ex);
        ex = '0;
        run_frame(pk, 5'd31, 16'd0, ex);

        // start held high: one frame per IDLE visit
        do_reset();
        pk = '0; pk[0] = mk(1000, 4000);
        ex = '0; ex[0] = mk(1000, 4000);
        bus.newPeaks     = pk;
        bus.iirConst     = 5'd2;
        bus.minAmplitude = 16'd0;
        for (int f = 0; f < 3; f++) exp_q.push_back(ex);
        bus.start = 1'b1;
        repeat (330) @(negedge clk);
        bus.start = 1'b0;
        wait_drain(400);
        repeat (200) @(negedge clk);

        // reset mid-MATCH: no finished, table cleared, fresh frame sees empty table
        pk = '0; pk[0] = mk(1100, 900);
        bus.newPeaks = pk;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (50) @(negedge clk);
        do_reset();
        repeat (200) @(negedge clk);
        check_cleared("abort");
        pk = '0; pk[4] = mk(3000, 1234);
        ex = '0; ex[0] = mk(3000, 1234);
        run_frame(pk, 5'd2, 16'd0, ex);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
